// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALUOp encodings, opcode constants and the
// decoded-control bundle carried down the pipeline.
package cpu_pkg;

  localparam logic [1:0] ALUOP_LW_SW  = 2'b00;
  localparam logic [1:0] ALUOP_BEQ    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BUBBLE = 2'b11;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '{
    ALUOp:    ALUOP_BUBBLE,
    ALUSrc:   1'b0,
    RegWrite: 1'b0,
    MemtoReg: 1'b0,
    MemRead:  1'b0,
    MemWrite: 1'b0
  };

  // An invalid slot must never carry side-effecting control.
  function automatic ctrl_t bubble_mask(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field group: reset/flush load CLR_VAL, stall holds, otherwise
// the group captures its input.
module pipe_field_reg #(
  parameter int          W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_reg <= CLR_VAL;
    end else if (!stall) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush and valid tracking.
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              valid_o,
  output logic              ex_load_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int DATA_GRP_W = 4 * DATA_W;
  localparam int ADDR_GRP_W = 10 + 3 * REG_AW;

  ctrl_t ctrl_in;
  ctrl_t ctrl_next;
  ctrl_t ctrl_q;

  logic [DATA_GRP_W-1:0] data_next;
  logic [DATA_GRP_W-1:0] data_q;
  logic [ADDR_GRP_W-1:0] addr_next;
  logic [ADDR_GRP_W-1:0] addr_q;
  logic                  valid_q;

  assign ctrl_in = '{
    ALUOp:    ALUOp_i,
    ALUSrc:   ALUSrc_i,
    RegWrite: RegWrite_i,
    MemtoReg: MemtoReg_i,
    MemRead:  MemRead_i,
    MemWrite: MemWrite_i
  };

  // Masking here keeps the bubble invariant true for loads with id_valid_i = 0.
  assign ctrl_next = bubble_mask(ctrl_in, id_valid_i);
  assign data_next = {pc_i, rs1_data_i, rs2_data_i, imm_i};
  assign addr_next = {funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i};

  pipe_field_reg #(
    .W       (CTRL_W),
    .CLR_VAL (CTRL_BUBBLE)
  ) u_ctrl (
    .clk   (clk_i),
    .rst   (rst_i),
    .stall (stall_i),
    .flush (flush_i),
    .d     (ctrl_next),
    .q     (ctrl_q)
  );

  pipe_field_reg #(
    .W       (1),
    .CLR_VAL (1'b0)
  ) u_valid (
    .clk   (clk_i),
    .rst   (rst_i),
    .stall (stall_i),
    .flush (flush_i),
    .d     (id_valid_i),
    .q     (valid_q)
  );

  pipe_field_reg #(
    .W       (DATA_GRP_W),
    .CLR_VAL ('0)
  ) u_data (
    .clk   (clk_i),
    .rst   (rst_i),
    .stall (stall_i),
    .flush (flush_i),
    .d     (data_next),
    .q     (data_q)
  );

  pipe_field_reg #(
    .W       (ADDR_GRP_W),
    .CLR_VAL ('0)
  ) u_addr (
    .clk   (clk_i),
    .rst   (rst_i),
    .stall (stall_i),
    .flush (flush_i),
    .d     (addr_next),
    .q     (addr_q)
  );

  assign ALUOp_o    = ctrl_q.ALUOp;
  assign ALUSrc_o   = ctrl_q.ALUSrc;
  assign RegWrite_o = ctrl_q.RegWrite;
  assign MemtoReg_o = ctrl_q.MemtoReg;
  assign MemRead_o  = ctrl_q.MemRead;
  assign MemWrite_o = ctrl_q.MemWrite;

  assign {pc_o, rs1_data_o, rs2_data_o, imm_o}        = data_q;
  assign {funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o} = addr_q;

  assign valid_o   = valid_q;
  assign ex_load_o = valid_q & ctrl_q.MemRead;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // A bubble enters EX on every flush and on every load of an empty ID slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      if (flush_i || (!stall_i && !id_valid_i)) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
      if (stall_i && !flush_i) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign bubble_cnt_o = bubble_cnt_reg;
  assign stall_cnt_o  = stall_cnt_reg;
`else
  assign bubble_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Table-driven bench for id_ex_pipe_reg plus hand sequences for reset,
// reset-during-stall and the perf counters.
module tb_id_ex_pipe_reg;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [1:0]  ALUOp_i;
  logic        ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [1:0]  ALUOp_o;
  logic        ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        valid_o, ex_load_o;
  logic [31:0] bubble_cnt_o, stall_cnt_o;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct_i(funct_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .funct_o(funct_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .valid_o(valid_o),
    .ex_load_o(ex_load_o), .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic        stall, flush, idv;
    ctrl_t       ctrl;
    logic [31:0] pc, a, b, imm;
    logic [9:0]  funct;
    logic [4:0]  r1, r2, rd;
  } in_t;

  typedef struct {
    ctrl_t       ctrl;
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [9:0]  funct;
    logic [4:0]  r1, r2, rd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
    logic chk_data;
  } vec_t;

  localparam ctrl_t C_LW  = 7'b00_1_1_1_1_0;
  localparam ctrl_t C_ADD = 7'b10_0_1_0_0_0;
  localparam ctrl_t C_SW  = 7'b00_1_0_0_0_1;
  localparam ctrl_t C_BEQ = 7'b01_0_0_0_0_0;
  localparam ctrl_t C_BUB = 7'b11_0_0_0_0_0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[11];

  function automatic in_t mk_in(logic st, logic fl, logic v, ctrl_t c, logic [31:0] pc,
                                logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [9:0] f, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
    in_t x;
    x.stall = st; x.flush = fl; x.idv = v; x.ctrl = c;
    x.pc = pc; x.a = a; x.b = b; x.imm = imm;
    x.funct = f; x.r1 = r1; x.r2 = r2; x.rd = rd;
    return x;
  endfunction

  function automatic out_t mk_out(ctrl_t c, logic v, logic [31:0] pc, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] imm, logic [9:0] f,
                                  logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
    out_t o;
    o.ctrl = c; o.valid = v; o.pc = pc; o.a = a; o.b = b; o.imm = imm;
    o.funct = f; o.r1 = r1; o.r2 = r2; o.rd = rd;
    return o;
  endfunction

  task automatic drive(input in_t x);
    stall_i = x.stall; flush_i = x.flush; id_valid_i = x.idv;
    {ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = x.ctrl;
    pc_i = x.pc; rs1_data_i = x.a; rs2_data_i = x.b; imm_i = x.imm;
    funct_i = x.funct; rs1_addr_i = x.r1; rs2_addr_i = x.r2; rd_addr_i = x.rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input out_t e, input logic chk_data);
    chk({tag, ".ctrl"}, 32'({ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}),
        32'(e.ctrl));
    chk({tag, ".valid"}, 32'(valid_o), 32'(e.valid));
    chk({tag, ".ex_load"}, 32'(ex_load_o), 32'(e.valid & e.ctrl.MemRead));
    chk({tag, ".bubble_inv"}, 32'({RegWrite_o, MemRead_o, MemWrite_o} & {3{~valid_o}}), 32'd0);
    if (chk_data) begin
      chk({tag, ".pc"}, pc_o, e.pc);
      chk({tag, ".rs1_data"}, rs1_data_o, e.a);
      chk({tag, ".rs2_data"}, rs2_data_o, e.b);
      chk({tag, ".imm"}, imm_o, e.imm);
      chk({tag, ".funct"}, 32'(funct_o), 32'(e.funct));
      chk({tag, ".addrs"}, 32'({rs1_addr_o, rs2_addr_o, rd_addr_o}), 32'({e.r1, e.r2, e.rd}));
    end
  endtask

  initial begin
    in_t  lw_in, add_in, sw_in, sw_st, sub_fl, beq_in, beq_fs, nv_in;
    out_t zero_out, lw_out, add_out, sw_out, beq_out, nv_out;
    logic [31:0] exp_bub, exp_stl;

    lw_in  = mk_in(0, 0, 1, C_LW,  32'h100, 32'h1000, 32'h22, 32'h10, 10'h002, 5'd2, 5'd0, 5'd5);
    add_in = mk_in(0, 0, 1, C_ADD, 32'h104, 32'h7, 32'h9, 32'h0, 10'h000, 5'd1, 5'd2, 5'd3);
    sw_st  = mk_in(1, 0, 1, C_SW,  32'h108, 32'h2000, 32'h55, 32'h8, 10'h002, 5'd4, 5'd6, 5'd0);
    sw_in  = sw_st; sw_in.stall = 0;
    sub_fl = mk_in(0, 1, 1, C_ADD, 32'h10c, 32'h11, 32'h5, 32'h0, 10'h100, 5'd8, 5'd9, 5'd7);
    beq_in = mk_in(0, 0, 1, C_BEQ, 32'h110, 32'h3, 32'h3, 32'hFFFF_FFF8, 10'h000, 5'd3, 5'd3, 5'd12);
    beq_fs = beq_in; beq_fs.stall = 1; beq_fs.flush = 1;
    nv_in  = lw_in; nv_in.idv = 0;

    zero_out = mk_out(C_BUB, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw_out   = mk_out(C_LW,  1, 32'h100, 32'h1000, 32'h22, 32'h10, 10'h002, 5'd2, 5'd0, 5'd5);
    add_out  = mk_out(C_ADD, 1, 32'h104, 32'h7, 32'h9, 32'h0, 10'h000, 5'd1, 5'd2, 5'd3);
    sw_out   = mk_out(C_SW,  1, 32'h108, 32'h2000, 32'h55, 32'h8, 10'h002, 5'd4, 5'd6, 5'd0);
    beq_out  = mk_out(C_BEQ, 1, 32'h110, 32'h3, 32'h3, 32'hFFFF_FFF8, 10'h000, 5'd3, 5'd3, 5'd12);
    nv_out   = mk_out(C_BUB, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = '{i: lw_in,  e: lw_out,   chk_data: 1};
    vecs[1]  = '{i: add_in, e: add_out,  chk_data: 1};
    vecs[2]  = '{i: sw_st,  e: add_out,  chk_data: 1};
    vecs[3]  = '{i: sw_st,  e: add_out,  chk_data: 1};
    vecs[4]  = '{i: sw_st,  e: add_out,  chk_data: 1};
    vecs[5]  = '{i: sw_in,  e: sw_out,   chk_data: 1};
    vecs[6]  = '{i: sub_fl, e: zero_out, chk_data: 1};
    vecs[7]  = '{i: beq_in, e: beq_out,  chk_data: 1};
    vecs[8]  = '{i: beq_fs, e: zero_out, chk_data: 1};
    vecs[9]  = '{i: nv_in,  e: nv_out,   chk_data: 0};
    vecs[10] = '{i: lw_in,  e: lw_out,   chk_data: 1};

    // Reset for two cycles with busy inputs.
    drive(lw_in);
    stall_i = 1'b1;
    rst_i = 1'b1;
    step();
    step();
    check_out("reset", zero_out, 1);
    $display("txn reset valid=%0d ALUOp=%b", valid_o, ALUOp_o);
    rst_i = 1'b0;

    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].i);
      step();
      check_out($sformatf("vec%0d", k), vecs[k].e, vecs[k].chk_data);
      $display("txn vec%0d stall=%0d flush=%0d idv=%0d -> valid=%0d ALUOp=%b rd=%0d pc=%h",
               k, vecs[k].i.stall, vecs[k].i.flush, vecs[k].i.idv,
               valid_o, ALUOp_o, rd_addr_o, pc_o);
    end

    // Reset while stalling must still clear the loaded lw.
    drive(sw_st);
    rst_i = 1'b1;
    step();
    check_out("rst_in_stall", zero_out, 1);
    $display("txn rst_in_stall valid=%0d pc=%h", valid_o, pc_o);
    chk("cnt_rst.bubble", bubble_cnt_o, 32'd0);
    chk("cnt_rst.stall", stall_cnt_o, 32'd0);
    rst_i = 1'b0;

    // Counter sequence: 4 flushes, 2 stall-only, 1 empty load.
    drive(sub_fl);
    repeat (4) step();
    drive(sw_st);
    repeat (2) step();
    drive(nv_in);
    step();
`ifdef ID_EX_PERF_CNT_EN
    exp_bub = 32'd5;
    exp_stl = 32'd2;
`else
    exp_bub = 32'd0;
    exp_stl = 32'd0;
`endif
    chk("cnt.bubble", bubble_cnt_o, exp_bub);
    chk("cnt.stall", stall_cnt_o, exp_stl);
    $display("txn counters bubble=%0d stall=%0d", bubble_cnt_o, stall_cnt_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
